// File: rtl/ccff_chain_loader.sv
// Config-chain loader: serialises bitstream words onto ccff_head, gates prog_clk
// via shift_en for exactly CHAIN_LEN bits and folds the displaced tail into a parity.
module ccff_chain_loader #(
    parameter int CHAIN_LEN = 58,
    parameter int WORD_W    = 8,
    parameter int CNT_W     = 6
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    input  logic              abort,
    input  logic [WORD_W-1:0] word_data,
    input  logic              word_valid,
    output logic              word_ready,
    output logic              ccff_head,
    output logic              shift_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  bit_cnt,
    output logic              tail_parity
);

    localparam int REM_W = $clog2(WORD_W + 1);

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    state_t            state, state_n;
    logic [WORD_W-1:0] buffer, buffer_n;
    logic [REM_W-1:0]  rem, rem_n;
    logic [CNT_W-1:0]  cnt_n;
    logic              parity_n;
    logic              shift_n;
    logic              xfer;
    logic [CNT_W:0]    fill;

    // rem counts buffered bits including the one currently on ccff_head
    assign fill       = (CNT_W+1)'(bit_cnt) + (CNT_W+1)'(rem);
    assign word_ready = (state == LOAD) && (rem <= REM_W'(1))
                        && (fill < (CNT_W+1)'(CHAIN_LEN));
    assign xfer       = word_valid && word_ready;
    assign ccff_head  = buffer[0];
    assign busy       = (state == LOAD);
    assign done       = (state == DONE);

    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            state       <= IDLE;
            buffer      <= '0;
            rem         <= '0;
            bit_cnt     <= '0;
            tail_parity <= 1'b0;
            shift_en    <= 1'b0;
        end else begin
            state       <= state_n;
            buffer      <= buffer_n;
            rem         <= rem_n;
            bit_cnt     <= cnt_n;
            tail_parity <= parity_n;
            shift_en    <= shift_n;
        end
    end

    always_comb begin
        state_n  = state;
        buffer_n = buffer;
        rem_n    = rem;
        cnt_n    = bit_cnt;
        parity_n = tail_parity;
        if (abort) begin
            state_n  = IDLE;
            buffer_n = '0;
            rem_n    = '0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state_n  = LOAD;
                        buffer_n = '0;
                        rem_n    = '0;
                        cnt_n    = '0;
                        parity_n = 1'b0;
                    end
                end
                LOAD: begin
                    if (rem != '0) begin
                        cnt_n    = bit_cnt + 1'b1;
                        parity_n = tail_parity ^ ccff_tail;
                        buffer_n = buffer >> 1;
                        rem_n    = rem - 1'b1;
                    end
                    // a word arrives only as the last buffered bit leaves
                    if (xfer) begin
                        buffer_n = word_data;
                        rem_n    = REM_W'(WORD_W);
                    end
                    if (cnt_n == CNT_W'(CHAIN_LEN)) begin
                        state_n  = DONE;
                        buffer_n = '0;
                        rem_n    = '0;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
        shift_n = (state_n == LOAD) && (rem_n != '0);
    end

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Bench for ccff_chain_loader: table of full loads plus abort/reset sequences;
// head bits are scoreboarded from accepted words, tail parity from the driven pattern.
module tb_ccff_chain_loader;

    localparam int CHAIN_LEN = 58;
    localparam int WORD_W    = 8;
    localparam int CNT_W     = 6;

    logic             prog_clk = 1'b0;
    logic             pReset;
    logic             start;
    logic             abort;
    logic [WORD_W-1:0] word_data;
    logic             word_valid;
    logic             word_ready;
    logic             ccff_head;
    logic             shift_en;
    logic             ccff_tail;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] bit_cnt;
    logic             tail_parity;

    ccff_chain_loader #(
        .CHAIN_LEN(CHAIN_LEN),
        .WORD_W(WORD_W),
        .CNT_W(CNT_W)
    ) dut (
        .prog_clk(prog_clk),
        .pReset(pReset),
        .start(start),
        .abort(abort),
        .word_data(word_data),
        .word_valid(word_valid),
        .word_ready(word_ready),
        .ccff_head(ccff_head),
        .shift_en(shift_en),
        .ccff_tail(ccff_tail),
        .busy(busy),
        .done(done),
        .bit_cnt(bit_cnt),
        .tail_parity(tail_parity)
    );

    always #5 prog_clk = ~prog_clk;

    typedef struct {
        logic [7:0]  base;
        logic [7:0]  step;
        bit          toggle;
        logic [57:0] tail;
        logic        exp_par;
        bit          mid_start;
    } vec_t;

    vec_t        vecs[4];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic        q[$];
    logic [57:0] tail_pat;
    int          sh_cnt;
    int          run;
    int          max_run;
    logic        exp_par;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(output bit acc);
        logic exp_bit;
        #1;
        acc = word_valid && word_ready;
        if (shift_en === 1'b1) begin
            run++;
            if (run > max_run) max_run = run;
            if (q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL head_underflow: shift with no queued bit");
            end else begin
                exp_bit = q.pop_front();
                check("ccff_head", 64'(ccff_head), 64'(exp_bit));
            end
            if (!abort && !pReset) begin
                exp_par ^= ccff_tail;
                sh_cnt++;
            end
        end else begin
            run = 0;
        end
        if (acc) for (int b = 0; b < WORD_W; b++) q.push_back(word_data[b]);
        @(posedge prog_clk);
        #1;
        ccff_tail = (sh_cnt < CHAIN_LEN) ? tail_pat[sh_cnt] : 1'b0;
    endtask

    task automatic arm(input logic [57:0] pat);
        q.delete();
        sh_cnt    = 0;
        exp_par   = 1'b0;
        run       = 0;
        max_run   = 0;
        tail_pat  = pat;
        ccff_tail = pat[0];
    endtask

    task automatic check_reset_vals(input string tag);
        word_valid = 1'b1;
        #1;
        check({tag, "_word_ready"}, 64'(word_ready), 64'd0);
        check({tag, "_head"}, 64'(ccff_head), 64'd0);
        check({tag, "_shift_en"}, 64'(shift_en), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_bit_cnt"}, 64'(bit_cnt), 64'd0);
        check({tag, "_parity"}, 64'(tail_parity), 64'd0);
        word_valid = 1'b0;
    endtask

    task automatic run_load(input vec_t v);
        bit acc;
        int k;
        int cyc;
        arm(v.tail);
        start = 1'b1;
        tick(acc);
        start = 1'b0;
        check("load_busy", 64'(busy), 64'd1);
        check("load_cnt0", 64'(bit_cnt), 64'd0);
        check("load_par0", 64'(tail_parity), 64'd0);
        k   = 0;
        cyc = 0;
        while (done !== 1'b1 && cyc < 400) begin
            word_valid = v.toggle ? (cyc % 2 == 0) : 1'b1;
            word_data  = 8'(int'(v.base) + k * int'(v.step));
            start      = v.mid_start && (cyc == 10);
            tick(acc);
            if (acc) k++;
            cyc++;
        end
        word_valid = 1'b0;
        start      = 1'b0;
        check("done", 64'(done), 64'd1);
        check("bit_cnt", 64'(bit_cnt), 64'(CHAIN_LEN));
        check("tail_parity", 64'(tail_parity), 64'(v.exp_par));
        check("words_taken", 64'(k), 64'd8);
        check("bits_dropped", 64'(q.size()), 64'd6);
        check("shifts_seen", 64'(sh_cnt), 64'(CHAIN_LEN));
        check("done_shift_en", 64'(shift_en), 64'd0);
        check("done_busy", 64'(busy), 64'd0);
        if (!v.toggle) check("shift_run", 64'(max_run), 64'(CHAIN_LEN));
    endtask

    initial begin
        bit acc;
        int c;
        vecs[0] = '{8'hA5, 8'h01, 1'b0, 58'h0F0_0000_0000_0001, 1'b1, 1'b0};
        vecs[1] = '{8'h3C, 8'h17, 1'b1, 58'h0, 1'b0, 1'b0};
        vecs[2] = '{8'h00, 8'h25, 1'b0, 58'h3FF_FFFF_FFFF_FFFF, 1'b0, 1'b1};
        vecs[3] = '{8'hFF, 8'hC3, 1'b1, 58'h7, 1'b1, 1'b0};

        pReset     = 1'b1;
        start      = 1'b0;
        abort      = 1'b0;
        word_valid = 1'b0;
        word_data  = '0;
        ccff_tail  = 1'b0;
        arm(58'h0);
        repeat (2) @(posedge prog_clk);
        #1;
        pReset = 1'b0;
        check_reset_vals("reset");

        foreach (vecs[i]) run_load(vecs[i]);

        // abort after 20 bits, then a fresh full load
        arm(58'h155_5555_5555_5555);
        start = 1'b1;
        tick(acc);
        start = 1'b0;
        c = 0;
        while (bit_cnt != 6'd20 && c < 200) begin
            word_valid = 1'b1;
            word_data  = 8'h5A ^ 8'(c);
            tick(acc);
            c++;
        end
        abort = 1'b1;
        tick(acc);
        abort = 1'b0;
        word_valid = 1'b1;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_shift_en", 64'(shift_en), 64'd0);
        check("abort_bit_cnt", 64'(bit_cnt), 64'd20);
        check("abort_word_ready", 64'(word_ready), 64'd0);
        check("abort_parity", 64'(tail_parity), 64'(exp_par));
        tick(acc);
        word_valid = 1'b0;
        check("abort_idle_shift", 64'(shift_en), 64'd0);
        check("abort_idle_cnt", 64'(bit_cnt), 64'd20);
        run_load(vecs[0]);

        // start+abort together: abort wins in DONE, IDLE and LOAD
        start = 1'b1;
        abort = 1'b1;
        tick(acc);
        check("sa_done_done", 64'(done), 64'd0);
        check("sa_done_busy", 64'(busy), 64'd0);
        check("sa_done_cnt", 64'(bit_cnt), 64'(CHAIN_LEN));
        tick(acc);
        check("sa_idle_busy", 64'(busy), 64'd0);
        abort = 1'b0;
        tick(acc);
        start = 1'b0;
        check("sa_start_busy", 64'(busy), 64'd1);
        arm(58'h0);
        word_valid = 1'b1;
        word_data  = 8'h81;
        repeat (3) tick(acc);
        start = 1'b1;
        abort = 1'b1;
        tick(acc);
        start      = 1'b0;
        abort      = 1'b0;
        word_valid = 1'b0;
        check("sa_load_busy", 64'(busy), 64'd0);
        check("sa_load_shift", 64'(shift_en), 64'd0);
        check("sa_load_cnt", 64'(bit_cnt), 64'd2);

        // synchronous reset in the middle of a load
        arm(58'h0);
        start = 1'b1;
        tick(acc);
        start = 1'b0;
        for (int i = 0; i < 30; i++) begin
            word_valid = 1'b1;
            word_data  = 8'(8'hC0 + i);
            tick(acc);
        end
        check("mid_busy", 64'(busy), 64'd1);
        pReset = 1'b1;
        tick(acc);
        pReset     = 1'b0;
        word_valid = 1'b0;
        check_reset_vals("mid_reset");
        run_load(vecs[1]);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
